// File: rtl/g_inv_seq_if.sv
// g_inv_seq_if: input/output valid-ready bundle for the inverse G sequencer.
interface g_inv_seq_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in, b_in, c_in, d_in, x, y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a_out, b_out, c_out, d_out;
  modport master (
    output in_valid, a_in, b_in, c_in, d_in, x, y, out_ready,
    input  in_ready, out_valid, a_out, b_out, c_out, d_out
  );
  modport slave (
    input  in_valid, a_in, b_in, c_in, d_in, x, y, out_ready,
    output in_ready, out_valid, a_out, b_out, c_out, d_out
  );
endinterface

// File: rtl/g_inv_seq.sv
// g_inv_seq: sequential inverse of the two-half BLAKE2 G mix, one half per clock.
// Optional G_INV_SELFCHECK_EN re-runs forward G on the result and flags mismatches on err.
module g_inv_seq #(
  parameter int W   = 32,
  parameter int RD0 = 16,
  parameter int RB0 = 12,
  parameter int RD1 = 8,
  parameter int RB1 = 7
) (
  input logic clk,
  input logic rst_n,
  g_inv_seq_if.slave bus
`ifdef G_INV_SELFCHECK_EN
  , output logic err
`endif
);
  if (RD0 <= 0 || RD0 >= W || RB0 <= 0 || RB0 >= W ||
      RD1 <= 0 || RD1 >= W || RB1 <= 0 || RB1 >= W) begin : g_bad_rot
    $error("g_inv_seq: rotate amounts must satisfy 0 < r < W");
  end
`ifdef G_INV_SELFCHECK_EN
  typedef enum logic [2:0] {IDLE, H1, H0, CHK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, H1, H0, DONE} state_t;
`endif
  state_t state, next;
  logic in_ready, out_valid;
  logic [4*W-1:0] st;
  logic [W-1:0] xr, yr;
  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
    return (v << n) | (v >> (W - n));
  endfunction
  // Each step uses the words already restored by the previous step.
  function automatic logic [4*W-1:0] inv_half(input logic [4*W-1:0] s, input logic [W-1:0] m,
                                              input int rd, input int rb);
    logic [W-1:0] a, b, c, d;
    {a, b, c, d} = s;
    b = rotl(b, rb) ^ c;
    c = c - d;
    d = rotl(d, rd) ^ a;
    a = a - b - m;
    return {a, b, c, d};
  endfunction
`ifdef G_INV_SELFCHECK_EN
  logic [4*W-1:0] chk_in;
  logic err_r;
  function automatic logic [4*W-1:0] fwd_half(input logic [4*W-1:0] s, input logic [W-1:0] m,
                                              input int rd, input int rb);
    logic [W-1:0] a, b, c, d;
    {a, b, c, d} = s;
    a = a + b + m;
    d = rotl(d ^ a, W - rd);
    c = c + d;
    b = rotl(b ^ c, W - rb);
    return {a, b, c, d};
  endfunction
  assign err = err_r;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    case (state)
      IDLE: next = bus.in_valid ? H1 : IDLE;
      H1:   next = H0;
`ifdef G_INV_SELFCHECK_EN
      H0:   next = CHK;
      CHK:  next = DONE;
`else
      H0:   next = DONE;
`endif
      DONE: next = bus.out_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0;
      xr <= '0;
      yr <= '0;
`ifdef G_INV_SELFCHECK_EN
      chk_in <= '0;
      err_r <= 1'b0;
`endif
    end else begin
      if (state == IDLE && bus.in_valid) begin
        st <= {bus.a_in, bus.b_in, bus.c_in, bus.d_in};
        xr <= bus.x;
        yr <= bus.y;
      end else if (state == H1) st <= inv_half(st, yr, RD1, RB1);
      else if (state == H0) st <= inv_half(st, xr, RD0, RB0);
`ifdef G_INV_SELFCHECK_EN
      if (state == IDLE && bus.in_valid) chk_in <= {bus.a_in, bus.b_in, bus.c_in, bus.d_in};
      if (state == CHK) err_r <= fwd_half(fwd_half(st, xr, RD0, RB0), yr, RD1, RB1) != chk_in;
      else if (state == DONE && bus.out_ready) err_r <= 1'b0;
`endif
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign {bus.a_out, bus.b_out, bus.c_out, bus.d_out} = st;
endmodule

// File: tb/tb_g_inv_seq.sv
// tb_g_inv_seq: directed and random checks of g_inv_seq against a forward-G model.
module tb_g_inv_seq;
  localparam int RD0 = 16, RB0 = 12, RD1 = 8, RB1 = 7;
`ifdef G_INV_SELFCHECK_EN
  localparam int LAT = 4;
  logic err;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  g_inv_seq_if #(.W(32)) bus ();
  g_inv_seq dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef G_INV_SELFCHECK_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ror(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction
  function automatic logic [127:0] fwd_g(input logic [127:0] s, input logic [31:0] x, y);
    logic [31:0] a, b, c, d;
    {a, b, c, d} = s;
    a = a + b + x; d = ror(d ^ a, RD0); c = c + d; b = ror(b ^ c, RB0);
    a = a + b + y; d = ror(d ^ a, RD1); c = c + d; b = ror(b ^ c, RB1);
    return {a, b, c, d};
  endfunction
  function automatic logic [127:0] outs();
    return {bus.a_out, bus.b_out, bus.c_out, bus.d_out};
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [127:0] s, input logic [31:0] x, input logic [31:0] y);
    {bus.a_in, bus.b_in, bus.c_in, bus.d_in} = s;
    bus.x = x;
    bus.y = y;
  endtask
  // Present one input at a negedge in IDLE, then wait (bounded) for out_valid.
  task automatic op(input logic [127:0] s, input logic [31:0] x, input logic [31:0] y,
                    output logic [127:0] got, output int lat);
    drive(s, x, y);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    got = outs();
  endtask
  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  initial begin
    logic [127:0] s, m, got;
    logic [31:0] x, y;
    int lat;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive('0, '0, '0);
    repeat (3) begin
      @(negedge clk);
      drive(rnd128(), $urandom, $urandom);
      bus.in_valid = 1'($urandom);
      bus.out_ready = 1'($urandom);
    end
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_outputs", outs(), 0);
`ifdef G_INV_SELFCHECK_EN
    check("rst_err", err, 0);
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    op('0, '0, '0, got, lat);
    check("zero_lat", lat, LAT);
    check("zero_out", got, 0);
`ifdef G_INV_SELFCHECK_EN
    check("zero_err", err, 0);
`endif
    take();
    op({32'd5, 32'd0, 32'd0, 32'd0}, '0, '0, got, lat);
    check("dir_lat", lat, LAT);
    check("dir_out", got, {32'd5, 32'd0, 32'hFFFFFFFB, 32'h00050005});
    take();
    s = {32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A};
    x = 32'h01234567;
    y = 32'h89ABCDEF;
    m = fwd_g(s, x, y);
    op(m, x, y, got, lat);
    check("rt_iv_lat", lat, LAT);
    check("rt_iv_out", got, s);
`ifdef G_INV_SELFCHECK_EN
    check("rt_iv_err", err, 0);
`endif
    // Backpressure: hold the result while new inputs knock on the door.
    for (int i = 0; i < 10; i++) begin
      drive(rnd128(), $urandom, $urandom);
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("bp_out", outs(), s);
      check("bp_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    take();
    repeat (3) begin
      check("bp_after_in_ready", bus.in_ready, 1);
      check("bp_after_valid", bus.out_valid, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 1000; i++) begin
      s = rnd128();
      x = $urandom;
      y = $urandom;
      m = fwd_g(s, x, y);
      op(m, x, y, got, lat);
      check("rt_rand_lat", lat, LAT);
      check("rt_rand_out", got, s);
`ifdef G_INV_SELFCHECK_EN
      check("rt_rand_err", err, 0);
`endif
      take();
    end
    drive(rnd128(), $urandom, $urandom);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_valid", bus.out_valid, 0);
    check("abort_outputs", outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("abort_no_valid", bus.out_valid, 0);
    end
`ifdef G_INV_SELFCHECK_EN
    s = rnd128();
    x = $urandom;
    y = $urandom;
    m = fwd_g(s, x, y);
    drive(m, x, y);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    force dut.chk_in = m ^ 128'h1;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("corrupt_lat", lat, LAT);
    check("corrupt_err", err, 1);
    release dut.chk_in;
    take();
    check("corrupt_err_clr", err, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
